// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM states,
// forward-select codes and the legal load-bubble range.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LD_WAIT  = 2'd1,
    MDU_BUSY = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int LOAD_STALL_MIN = 1;
  localparam int LOAD_STALL_MAX = 7;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Operand forward select for one Execute source register.
// Memory stage wins over Writeback; x0 is never forwarded.
module fwd_sel
  import hazard_ctrl_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rd_m,
  input  logic [AW-1:0] rd_w,
  input  logic          reg_write_m,
  input  logic          reg_write_w,
  output logic [1:0]    fwd
);

  always_comb begin
    fwd = FWD_RF;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs_addr))
      fwd = FWD_MEM;
    else if (reg_write_w && (rd_w != '0) && (rd_w == rs_addr))
      fwd = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use bubbles, mul/div stalls,
// branch flushes and saturating stall/flush performance counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1_addr_D,
  input  logic [REG_AW-1:0] rs2_addr_D,
  input  logic [REG_AW-1:0] rs1_addr_E,
  input  logic [REG_AW-1:0] rs2_addr_E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemReadE,
  input  logic              PCSrcE,
  input  logic              mdu_start_E,
  input  logic              mdu_done,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [2:0] LD_RELOAD = 3'(LOAD_STALL - 1);

  state_t          state_reg, state_next;
  logic [2:0]      ld_cnt_reg, ld_cnt_next;
  logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;
  logic            lu;
  logic            stall_f, stall_d, stall_e, flush_d, flush_e;
  logic [1:0]      fwd_a, fwd_b;

  fwd_sel #(.AW(REG_AW)) u_fwd_a (
    .rs_addr     (rs1_addr_E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .fwd         (fwd_a)
  );

  fwd_sel #(.AW(REG_AW)) u_fwd_b (
    .rs_addr     (rs2_addr_E),
    .rd_m        (RdM),
    .rd_w        (RdW),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .fwd         (fwd_b)
  );

  assign lu = MemReadE && (RdE != '0) && ((RdE == rs1_addr_D) || (RdE == rs2_addr_D));

  // Stall/flush must act in the same cycle the hazard is seen, so they are
  // decoded from the registered state plus the current pipeline inputs.
  always_comb begin
    state_next  = state_reg;
    ld_cnt_next = ld_cnt_reg;
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    stall_e     = 1'b0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (PCSrcE) begin
          flush_d = 1'b1;
          flush_e = 1'b1;
        end
        if (mdu_start_E) begin
          state_next = MDU_BUSY;
        end else if (lu && !PCSrcE) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
          if (LOAD_STALL > 1) begin
            state_next  = LD_WAIT;
            ld_cnt_next = LD_RELOAD;
          end
        end
      end
      LD_WAIT: begin
        if (PCSrcE) begin
          flush_d     = 1'b1;
          flush_e     = 1'b1;
          state_next  = IDLE;
          ld_cnt_next = 3'd0;
        end else begin
          stall_f     = 1'b1;
          stall_d     = 1'b1;
          flush_e     = 1'b1;
          ld_cnt_next = ld_cnt_reg - 3'd1;
          if (ld_cnt_reg <= 3'd1) begin
            state_next  = IDLE;
            ld_cnt_next = 3'd0;
          end
        end
      end
      MDU_BUSY: begin
        if (mdu_done) begin
          state_next = IDLE;
        end else begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      ld_cnt_reg    <= 3'd0;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      ld_cnt_reg <= ld_cnt_next;
      if (stall_f && (stall_cnt_reg != '1))
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      // FlushD is only ever raised by a taken branch, so it marks flush events.
      if (flush_d && (flush_cnt_reg != '1))
        flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
    end
  end

  // Reset forces every control output low immediately, not at the next edge.
  assign StallF    = stall_f & ~rst;
  assign StallD    = stall_d & ~rst;
  assign StallE    = stall_e & ~rst;
  assign FlushD    = flush_d & ~rst;
  assign FlushE    = flush_e & ~rst;
  assign ForwardAE = rst ? FWD_RF : fwd_a;
  assign ForwardBE = rst ? FWD_RF : fwd_b;
  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (LOAD_STALL=3, CNT_W=4).
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_addr_D, rs2_addr_D, rs1_addr_E, rs2_addr_E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW, MemReadE, PCSrcE, mdu_start_E, mdu_done;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, FlushD, FlushE;
  logic [3:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.REG_AW(5), .LOAD_STALL(3), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .rs1_addr_D(rs1_addr_D), .rs2_addr_D(rs2_addr_D),
    .rs1_addr_E(rs1_addr_E), .rs2_addr_E(rs2_addr_E), .RdE(RdE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemReadE(MemReadE), .PCSrcE(PCSrcE), .mdu_start_E(mdu_start_E),
    .mdu_done(mdu_done), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-12s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Pack control outputs as {StallF,StallD,StallE,FlushD,FlushE}.
  function automatic logic [31:0] ctl();
    return {27'd0, StallF, StallD, StallE, FlushD, FlushE};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    rs1_addr_D = 5'd7; rs2_addr_D = 5'd7; rs1_addr_E = 5'd5; rs2_addr_E = 5'd5;
    RdE = 5'd7; RdM = 5'd5; RdW = 5'd5;
    RegWriteM = 1'b1; RegWriteW = 1'b1; MemReadE = 1'b1;
    PCSrcE = 1'b0; mdu_start_E = 1'b0; mdu_done = 1'b0;
    #2;
    // Hazard and forward conditions present, but reset masks everything.
    chk("rst_ctl", ctl(), 32'h00);
    chk("rst_fwda", 32'(ForwardAE), 32'h0);
    chk("rst_fwdb", 32'(ForwardBE), 32'h0);
    chk("rst_scnt", 32'(stall_cnt), 32'h0);
    chk("rst_fcnt", 32'(flush_cnt), 32'h0);
    MemReadE = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;

    // Forwarding priority
    chk("fwd_mem", 32'(ForwardAE), 32'h2);
    chk("fwdb_mem", 32'(ForwardBE), 32'h2);
    RegWriteM = 1'b0; #1;
    chk("fwd_wb", 32'(ForwardAE), 32'h1);
    RdM = 5'd0; RdW = 5'd0; rs1_addr_E = 5'd0; #1;
    chk("fwd_x0", 32'(ForwardAE), 32'h0);
    RegWriteM = 1'b1; RdM = 5'd3; rs2_addr_E = 5'd3; RdW = 5'd3; #1;
    chk("fwdb_mem2", 32'(ForwardBE), 32'h2);
    RegWriteM = 1'b0; RegWriteW = 1'b0;

    // Load-use: 3 bubbles
    tick();
    MemReadE = 1'b1; RdE = 5'd7; rs1_addr_D = 5'd1; rs2_addr_D = 5'd7; #1;
    chk("lu_c0", ctl(), 32'h19);
    tick(); MemReadE = 1'b0; #1;
    chk("lu_c1", ctl(), 32'h19);
    tick();
    chk("lu_c2", ctl(), 32'h19);
    tick();
    chk("lu_end", ctl(), 32'h00);
    chk("lu_state", 32'(dut.state_reg), 32'(IDLE));
    chk("lu_scnt", 32'(stall_cnt), 32'h3);

    // Branch aborts LD_WAIT in its 2nd cycle
    MemReadE = 1'b1; #1;
    chk("ab_c0", ctl(), 32'h19);
    tick(); MemReadE = 1'b0; #1;
    chk("ab_c1", ctl(), 32'h19);
    tick(); PCSrcE = 1'b1; #1;
    chk("ab_flush", ctl(), 32'h03);
    tick(); PCSrcE = 1'b0; #1;
    chk("ab_state", 32'(dut.state_reg), 32'(IDLE));
    chk("ab_ctl", ctl(), 32'h00);
    chk("ab_fcnt", 32'(flush_cnt), 32'h1);
    chk("ab_scnt", 32'(stall_cnt), 32'h5);

    // Flush overrides a simultaneous load-use
    MemReadE = 1'b1; PCSrcE = 1'b1; #1;
    chk("fl_over", ctl(), 32'h03);
    tick(); MemReadE = 1'b0; PCSrcE = 1'b0; #1;
    chk("fl_fcnt", 32'(flush_cnt), 32'h2);
    chk("fl_ctl", ctl(), 32'h00);

    // mul/div start with coincident load-use: no bubble, then 4 stall cycles
    mdu_start_E = 1'b1; MemReadE = 1'b1; #1;
    chk("md_start", ctl(), 32'h00);
    tick(); mdu_start_E = 1'b0; MemReadE = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      PCSrcE = (i == 2);
      #1;
      chk($sformatf("md_busy%0d", i), ctl(), 32'h1C);
      tick();
    end
    PCSrcE = 1'b0; mdu_done = 1'b1; #1;
    chk("md_done", ctl(), 32'h00);
    tick(); mdu_done = 1'b0; #1;
    chk("md_state", 32'(dut.state_reg), 32'(IDLE));
    chk("md_scnt", 32'(stall_cnt), 32'h9);
    chk("md_fcnt", 32'(flush_cnt), 32'h2);

    // Reset during MDU_BUSY
    mdu_start_E = 1'b1;
    tick(); mdu_start_E = 1'b0; #1;
    chk("rb_busy", ctl(), 32'h1C);
    #1; rst = 1'b1; #1;
    chk("rb_ctl", ctl(), 32'h00);
    chk("rb_state", 32'(dut.state_reg), 32'(IDLE));
    chk("rb_scnt", 32'(stall_cnt), 32'h0);
    tick(); rst = 1'b0; #1;
    chk("rb_rel", ctl(), 32'h00);
    tick();
    chk("rb_idle", 32'(dut.state_reg), 32'(IDLE));

    // Saturation: 20 stall cycles, 4-bit counter
    mdu_start_E = 1'b1;
    tick(); mdu_start_E = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    chk("sat_14", 32'(stall_cnt), 32'hE);
    for (int i = 0; i < 6; i++) tick();
    chk("sat_20", 32'(stall_cnt), 32'hF);
    chk("sat_ctl", ctl(), 32'h1C);
    mdu_done = 1'b1;
    tick(); mdu_done = 1'b0;
    tick();
    chk("sat_hold", 32'(stall_cnt), 32'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
